// File: rtl/vga_timing_pkg.sv
// Shared types and timing helpers for the VGA scan-timing generator.
// Colour-bar constants back the VGA_TESTPAT_EN build of vga_timing_ctrl.
package vga_timing_pkg;

  typedef logic [23:0] rgb_t;

  localparam int unsigned CNT_W     = 10;
  localparam int unsigned CNT_RANGE = 1 << CNT_W;

  localparam rgb_t BAR_WHITE   = 24'hFFFFFF;
  localparam rgb_t BAR_YELLOW  = 24'hFFFF00;
  localparam rgb_t BAR_CYAN    = 24'h00FFFF;
  localparam rgb_t BAR_GREEN   = 24'h00FF00;
  localparam rgb_t BAR_MAGENTA = 24'hFF00FF;
  localparam rgb_t BAR_RED     = 24'hFF0000;
  localparam rgb_t BAR_BLUE    = 24'h0000FF;
  localparam rgb_t BAR_BLACK   = 24'h000000;

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned sync_first(input int unsigned active, input int unsigned fp);
    return active + fp;
  endfunction

  function automatic int unsigned sync_last(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync);
    return active + fp + sync - 1;
  endfunction

  function automatic rgb_t bar_colour(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Pixel request/response bus between the scan-timing generator (master) and the frame source.
interface vga_timing_ctrl_if;
  import vga_timing_pkg::*;

  logic [9:0] h_addr;
  logic [9:0] v_addr;
  logic       addr_valid;
  rgb_t       vga_data;

  modport master (output h_addr, output v_addr, output addr_valid, input vga_data);
  modport slave  (input h_addr, input v_addr, input addr_valid, output vga_data);
endinterface

// File: rtl/vga_axis_counter.sv
// One scan axis: wrapping position counter with enable, carry-out on wrap,
// and active-region / sync-window decode of the current position.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       en,
  output logic [9:0] cnt,
  output logic       carry,
  output logic       active,
  output logic       in_sync
);

  localparam int unsigned TOTAL    = axis_total(ACTIVE, FP, SYNC, BP);
  localparam int unsigned LAST     = TOTAL - 1;
  localparam int unsigned SYNC_LO  = sync_first(ACTIVE, FP);
  localparam int unsigned SYNC_HI  = sync_last(ACTIVE, FP, SYNC);

  if (TOTAL > CNT_RANGE || ACTIVE == 0 || SYNC == 0) begin : g_bad_params
    $error("vga_axis_counter: axis timing does not fit a 10-bit counter");
  end

  logic [9:0] cnt_q, cnt_d;
  logic       at_last;

  always_comb begin
    at_last = (32'(cnt_q) == LAST);
    carry   = en & at_last;
    cnt_d   = cnt_q;
    if (en) begin
      cnt_d = at_last ? '0 : cnt_q + 10'd1;
    end
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign active  = (32'(cnt_q) < ACTIVE);
  assign in_sync = (32'(cnt_q) >= SYNC_LO) && (32'(cnt_q) <= SYNC_HI);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA scan-timing generator and two-stage pixel output stage, advancing on pix_en.
// Define VGA_TESTPAT_EN to replace vga_data with eight built-in vertical colour bars.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              pix_en,
  vga_timing_ctrl_if.master src,
  output logic              hsync,
  output logic              vsync,
  output logic              blank_n,
  output rgb_t              rgb,
  output logic              frame_start
);

  logic [9:0] h_cnt, v_cnt;
  logic       h_carry, v_carry, h_active, v_active, h_in_sync, v_in_sync;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clkin   (clkin),
    .rst     (rst),
    .en      (pix_en),
    .cnt     (h_cnt),
    .carry   (h_carry),
    .active  (h_active),
    .in_sync (h_in_sync)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clkin   (clkin),
    .rst     (rst),
    .en      (h_carry),
    .cnt     (v_cnt),
    .carry   (v_carry),
    .active  (v_active),
    .in_sync (v_in_sync)
  );

  // Stage 1: decoded request and raw sync
  logic       s1_valid_q, s1_valid_d;
  logic [9:0] s1_h_q, s1_h_d, s1_v_q, s1_v_d;
  logic       s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
  // Stage 2: DAC-facing outputs
  logic       hsync_q, vsync_q, blank_n_q;
  rgb_t       rgb_q, rgb_d, pix_colour;
  // Set while the counters sit at (0,0), so frame_start needs no wide compare
  logic       origin_q, frame_start_q;

  always_comb begin
    s1_valid_d = h_active & v_active;
    s1_h_d     = s1_valid_d ? h_cnt : '0;
    s1_v_d     = s1_valid_d ? v_cnt : '0;
    s1_hs_d    = h_in_sync ? SYNC_POL : ~SYNC_POL;
    s1_vs_d    = v_in_sync ? SYNC_POL : ~SYNC_POL;
    rgb_d      = s1_valid_q ? pix_colour : '0;
  end

`ifdef VGA_TESTPAT_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;
  assign pix_colour = bar_colour(3'(32'(s1_h_q) / BAR_W));
`else
  assign pix_colour = src.vga_data;
`endif

  always_ff @(posedge clkin) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_h_q     <= '0;
      s1_v_q     <= '0;
      s1_hs_q    <= ~SYNC_POL;
      s1_vs_q    <= ~SYNC_POL;
      hsync_q    <= ~SYNC_POL;
      vsync_q    <= ~SYNC_POL;
      blank_n_q  <= 1'b0;
      rgb_q      <= '0;
    end else if (pix_en) begin
      s1_valid_q <= s1_valid_d;
      s1_h_q     <= s1_h_d;
      s1_v_q     <= s1_v_d;
      s1_hs_q    <= s1_hs_d;
      s1_vs_q    <= s1_vs_d;
      hsync_q    <= s1_hs_q;
      vsync_q    <= s1_vs_q;
      blank_n_q  <= s1_valid_q;
      rgb_q      <= rgb_d;
    end
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      origin_q      <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= pix_en & origin_q;
      if (pix_en) begin
        origin_q <= v_carry;
      end
    end
  end

  assign src.h_addr     = s1_h_q;
  assign src.v_addr     = s1_v_q;
  assign src.addr_valid = s1_valid_q;
  assign hsync          = hsync_q;
  assign vsync          = vsync_q;
  assign blank_n        = blank_n_q;
  assign rgb            = rgb_q;
  assign frame_start    = frame_start_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl on a reduced 24x13 raster (16x8 visible).
// Checks reset values, per-tick pipeline contents, sync/frame intervals, pix_en gaps and mid-frame reset.
module tb_vga_timing_ctrl;

  // Reduced raster: H 16+2+3+3 = 24, V 8+1+2+2 = 13, frame = 312 ticks
  localparam int HA = 16;
  localparam int VA = 8;
  localparam int HT = 24;
  localparam int FT = 312;
  localparam int HS_LO = 18;
  localparam int HS_HI = 20;
  localparam int VS_LO = 9;
  localparam int VS_HI = 10;

  logic        clkin = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en = 1'b0;
  logic        hsync, vsync, blank_n, frame_start;
  logic [23:0] rgb;

  vga_timing_ctrl_if src_if ();

  always #5 clkin = ~clkin;

  // Frame source: colour is a pure function of the requested coordinate
  always_comb src_if.vga_data = {src_if.h_addr[7:0], src_if.v_addr[7:0], 8'h5A};

  vga_timing_ctrl #(
    .H_ACTIVE (16),
    .H_FP     (2),
    .H_SYNC   (3),
    .H_BP     (3),
    .V_ACTIVE (8),
    .V_FP     (1),
    .V_SYNC   (2),
    .V_BP     (2),
    .SYNC_POL (1'b0)
  ) dut (
    .clkin       (clkin),
    .rst         (rst),
    .pix_en      (pix_en),
    .src         (src_if.master),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank_n     (blank_n),
    .rgb         (rgb),
    .frame_start (frame_start)
  );

  int n_chk = 0;
  int n_bad = 0;
  int n_tick = 0;

  // Interval measurements, in pix_en ticks
  int   t_brise, t_hfall, t_vfall, t_fs;
  int   hs_width, hs_period, hs_lead, vs_width, vs_lead, fs_period;
  logic prev_blank, prev_hs, prev_vs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_colour(input int h, input int v);
`ifdef VGA_TESTPAT_EN
    case (h / 2)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
`else
    return {8'(h), 8'(v), 8'h5A};
`endif
  endfunction

  task automatic clr_meas();
    t_brise = -1; t_hfall = -1; t_vfall = -1; t_fs = -1;
    hs_width = -1; hs_period = -1; hs_lead = -1;
    vs_width = -1; vs_lead = -1; fs_period = -1;
    prev_blank = blank_n; prev_hs = hsync; prev_vs = vsync;
  endtask

  // One clkin cycle; expected outputs follow from the tick count alone:
  // stage 1 holds scan position n_tick-1, the DAC stage holds n_tick-2.
  task automatic step(input logic en, input logic r);
    int          c1, c2, h1, v1, h2, v2;
    logic        e_valid, e_blank, e_hs, e_vs, e_fs;
    logic [9:0]  e_h, e_v;
    logic [23:0] e_rgb;
    rst = r;
    pix_en = en;
    @(posedge clkin);
    #1;
    if (r) n_tick = 0;
    else if (en) n_tick++;

    e_valid = 1'b0; e_h = '0; e_v = '0; e_fs = 1'b0;
    if (n_tick >= 1) begin
      c1 = (n_tick - 1) % FT;
      h1 = c1 % HT;
      v1 = c1 / HT;
      e_valid = (h1 < HA) && (v1 < VA);
      e_h = e_valid ? 10'(h1) : 10'd0;
      e_v = e_valid ? 10'(v1) : 10'd0;
      e_fs = !r && en && (c1 == 0);
    end
    e_blank = 1'b0; e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1;
    if (n_tick >= 2) begin
      c2 = (n_tick - 2) % FT;
      h2 = c2 % HT;
      v2 = c2 / HT;
      e_blank = (h2 < HA) && (v2 < VA);
      e_rgb = e_blank ? exp_colour(h2, v2) : 24'h0;
      e_hs = !((h2 >= HS_LO) && (h2 <= HS_HI));
      e_vs = !((v2 >= VS_LO) && (v2 <= VS_HI));
    end

    check("h_addr", 32'(src_if.h_addr), 32'(e_h));
    check("v_addr", 32'(src_if.v_addr), 32'(e_v));
    check("addr_valid", 32'(src_if.addr_valid), 32'(e_valid));
    check("hsync", 32'(hsync), 32'(e_hs));
    check("vsync", 32'(vsync), 32'(e_vs));
    check("blank_n", 32'(blank_n), 32'(e_blank));
    check("rgb", 32'(rgb), 32'(e_rgb));
    check("frame_start", 32'(frame_start), 32'(e_fs));

    if (!r && en) begin
      if (!prev_blank && blank_n) t_brise = n_tick;
      if (prev_hs && !hsync) begin
        if (t_hfall >= 0) hs_period = n_tick - t_hfall;
        if (hs_lead < 0 && t_brise >= 0) hs_lead = n_tick - t_brise;
        t_hfall = n_tick;
      end
      if (!prev_hs && hsync && t_hfall >= 0) hs_width = n_tick - t_hfall;
      if (prev_vs && !vsync) begin
        t_vfall = n_tick;
        if (vs_lead < 0 && t_fs >= 0) vs_lead = n_tick - t_fs;
      end
      if (!prev_vs && vsync && t_vfall >= 0) vs_width = n_tick - t_vfall;
      if (frame_start) begin
        if (t_fs >= 0) fs_period = n_tick - t_fs;
        t_fs = n_tick;
      end
      prev_blank = blank_n;
      prev_hs = hsync;
      prev_vs = vsync;
    end
  endtask

  initial begin
    int start;
    int cyc;

    // Reset held with pix_en high
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);

    // Continuous pix_en for two frames and a bit
    clr_meas();
    for (int i = 0; i < 2 * FT + 30; i++) step(1'b1, 1'b0);
    check("hs_width", 32'(hs_width), 32'd3);
    check("hs_period", 32'(hs_period), 32'd24);
    check("hs_lead", 32'(hs_lead), 32'd18);
    check("vs_width", 32'(vs_width), 32'd48);
    check("vs_lead", 32'(vs_lead), 32'd217);
    check("fs_period", 32'(fs_period), 32'd312);

    // pix_en every 4th cycle with random dropouts; outputs must hold between ticks
    clr_meas();
    start = n_tick;
    cyc = 0;
    for (int i = 0; i < 6000 && n_tick < start + 2 * FT + 30; i++) begin
      step(((cyc % 4) == 0) && ($urandom_range(0, 4) != 0), 1'b0);
      cyc++;
    end
    check("gap_ticks_done", 32'(n_tick >= start + 2 * FT + 30), 32'd1);
    check("gap_hs_width", 32'(hs_width), 32'd3);
    check("gap_hs_period", 32'(hs_period), 32'd24);
    check("gap_vs_width", 32'(vs_width), 32'd48);
    check("gap_fs_period", 32'(fs_period), 32'd312);

    // Reset mid-frame at stage-1 position (h=10, v=5), then restart from origin
    for (int i = 0; i < FT + 2 && ((n_tick - 1) % FT) != 5 * HT + 10; i++) step(1'b1, 1'b0);
    check("mid_pos_reached", 32'((n_tick - 1) % FT), 32'(5 * HT + 10));
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    for (int i = 0; i < 60; i++) step(1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
